// File: rtl/uart_matrix_pkg.sv
// Shared constants for the UART matrix receiver: byte width, bit-FSM state encoding, baud helpers.
package uart_matrix_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_bit(input int clk_hz, input int baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchroniser, bit FSM and baud counter. byte_vld/byte_err are strobes
// asserted during the stop-sample cycle; there is no backpressure, so bytes must be taken as they come.
module uart_rx_byte
  import uart_matrix_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic [BYTE_W-1:0] byte_dat,
  output logic              byte_vld,
  output logic              byte_err,
  output logic              line_idle,
  output logic              line_fall
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF  = half_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              tick_full;
  logic              tick_half;

  assign tick_full = (cnt == CNT_FULL);
  assign tick_half = (cnt == CNT_HALF);
  assign line_fall = rx_prev & ~rx_sync;
  assign line_idle = (state == ST_IDLE);
  assign byte_dat  = shreg;
  assign byte_vld  = (state == ST_STOP) && tick_full && rx_sync;
  assign byte_err  = (state == ST_STOP) && tick_full && !rx_sync;

  // Synchroniser flops reset to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (line_fall) state <= ST_START;
        end
        ST_START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[BYTE_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_matrix_rx.sv
// Packs ELEMS UART bytes into one matrix word; m_valid rises 1 cycle after the last stop sample and a word
// completing while the held word is stalled is dropped (overrun). Optional inter-byte timeout: UART_RX_TIMEOUT_EN.
module uart_matrix_rx
  import uart_matrix_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int ELEMS        = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [BYTE_W*ELEMS-1:0] m_data,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int WORD_W    = BYTE_W * ELEMS;
  localparam int IDX_W     = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  logic [BYTE_W-1:0] byte_dat;
  logic              byte_vld;
  logic              byte_err;
  logic              line_idle;
  logic              line_fall;

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] word_full;
  logic              load_ok;
  logic              tmo_hit;

  uart_rx_byte #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_dat  (byte_dat),
    .byte_vld  (byte_vld),
    .byte_err  (byte_err),
    .line_idle (line_idle),
    .line_fall (line_fall)
  );

  // Assembly word with the incoming byte already merged, so the last byte can go straight to the holding register.
  always_comb begin
    word_full = asm_word;
    word_full[idx*BYTE_W +: BYTE_W] = byte_dat;
  end

  assign load_ok = !m_valid || m_ready;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_LIMIT + 1);

  logic [TMO_W-1:0] idle_cnt;

  assign tmo_hit = line_idle && (idx != '0) && (idle_cnt == TMO_W'(TMO_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!line_idle || (idx == '0) || line_fall || tmo_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TMO_W'(1);
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = &{1'b0, line_idle, line_fall, TMO_LIMIT[0]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      asm_word  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      frame_err <= byte_err;
      overrun   <= 1'b0;
      timeout   <= tmo_hit;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (byte_vld) begin
        asm_word <= word_full;
        if (idx == LAST_IDX) begin
          idx <= '0;
          if (load_ok) begin
            m_data  <= word_full;
            m_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (tmo_hit) begin
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_matrix_rx.sv
// Bench for uart_matrix_rx at a reduced line rate (17 clocks per bit) so whole frames stay short.
module tb_uart_matrix_rx;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUD_R   = 57_600;
  localparam int TMO_BITS = 20;
  localparam int CPB      = CLK_HZ / BAUD_R;
  localparam int HALF     = CPB / 2;
  // start edge on pin -> 2 sync cycles -> stop sample at t0+HALF+9*CPB -> registered outputs one cycle later
  localparam int OUT_LAT  = 2 + HALF + 9 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        frame_err;
  logic        overrun;
  logic        timeout;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_ferr, n_ovr, n_tmo;
  int vld_rise_cyc, ovr_cyc, ferr_cyc, last_start;
  logic vld_prev = 1'b0;
  logic [31:0] got_q[$];

  uart_matrix_rx #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .BAUD         (BAUD_R),
    .ELEMS        (4),
    .TIMEOUT_BITS (TMO_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (m_valid && !vld_prev) vld_rise_cyc = cyc;
      if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
      if (overrun) begin n_ovr++; ovr_cyc = cyc; end
      if (timeout) n_tmo++;
    end
    vld_prev = m_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_val);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic clear_counters();
    n_ferr = 0; n_ovr = 0; n_tmo = 0;
    vld_rise_cyc = -1; ovr_cyc = -1; ferr_cyc = -1;
    got_q.delete();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < 4; i++) w = w | (32'($urandom_range(0, 255)) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] q_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; uart_rx = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    clear_counters(); m_ready = 1'b1; idle(4);
    send_word(32'h04030201, 0);
    idle(CPB);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d words expected 1", got_q.size()); end
    n_checks++; if (q_at(0) !== 32'h04030201) begin n_fail++; $display("FAIL basic_word: got %h expected 04030201", q_at(0)); end
    n_checks++; if (vld_rise_cyc - last_start !== OUT_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", vld_rise_cyc - last_start, OUT_LAT); end
    n_checks++; if (n_ferr + n_ovr + n_tmo !== 0) begin n_fail++; $display("FAIL basic_flags: got %0d/%0d/%0d pulses expected none", n_ferr, n_ovr, n_tmo); end
  endtask

  task automatic test_overrun();
    clear_counters(); m_ready = 1'b0; idle(4);
    send_word(32'h04030201, 0);
    send_word(32'h08070605, 0);
    idle(CPB);
    n_checks++; if (n_ovr !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", n_ovr); end
    n_checks++; if (ovr_cyc - last_start !== OUT_LAT) begin n_fail++; $display("FAIL ovr_timing: got %0d expected %0d", ovr_cyc - last_start, OUT_LAT); end
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %b expected 1", m_valid); end
    n_checks++; if (m_data !== 32'h04030201) begin n_fail++; $display("FAIL ovr_held_data: got %h expected 04030201", m_data); end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_fall: got %b expected 0", m_valid); end
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== 32'h04030201) begin n_fail++; $display("FAIL ovr_drain: got %0d words first %h expected 1 word 04030201", got_q.size(), q_at(0)); end
  endtask

  task automatic test_frame_err();
    int aa_start;
    clear_counters(); m_ready = 1'b1; idle(4);
    send_byte(8'h01, 1'b1);
    aa_start = cyc;
    send_byte(8'hAA, 1'b0);
    idle(CPB);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(CPB);
    n_checks++; if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
    n_checks++; if (ferr_cyc - aa_start !== OUT_LAT) begin n_fail++; $display("FAIL ferr_timing: got %0d expected %0d", ferr_cyc - aa_start, OUT_LAT); end
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== 32'h04030201) begin n_fail++; $display("FAIL ferr_word: got %0d words first %h expected 1 word 04030201", got_q.size(), q_at(0)); end
  endtask

  task automatic test_false_start();
    clear_counters(); m_ready = 1'b1; idle(4);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b0;
      repeat ($urandom_range(1, HALF - 1)) @(negedge clk);
      idle(2 * CPB);
    end
    n_checks++; if (got_q.size() !== 0 || n_ferr !== 0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_quiet: got %0d words %0d frame errors valid %b expected none", got_q.size(), n_ferr, m_valid); end
    send_word(32'h44332211, 0);
    idle(CPB);
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== 32'h44332211) begin n_fail++; $display("FAIL glitch_word: got %0d words first %h expected 1 word 44332211", got_q.size(), q_at(0)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    clear_counters(); m_ready = 1'b1; idle(4);
    w = rand_word();
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    drive_bit(1'b0);
    drive_bit(w[16]);
    drive_bit(w[17]);
    uart_rx = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({m_valid, frame_err, overrun, timeout} !== 4'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 0000", {m_valid, frame_err, overrun, timeout}); end
    n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", m_data); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    w = rand_word();
    send_word(w, 0);
    idle(CPB);
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== w) begin n_fail++; $display("FAIL rstmid_word: got %0d words first %h expected 1 word %h", got_q.size(), q_at(0), w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    clear_counters(); m_ready = 1'b1; idle(4);
    for (int i = 0; i < 3; i++) exp_q.push_back(rand_word());
    for (int i = 0; i < 3; i++) send_word(exp_q[i], 0);
    idle(CPB);
    n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d words expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (q_at(i) !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, q_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] wa, wb;
    int k;
    clear_counters(); m_ready = 1'b0; idle(4);
    wa = rand_word(); wb = rand_word();
    send_word(wa, 0);
    for (int i = 0; i < 3; i++) send_byte(wb[8*i +: 8], 1'b1);
    k = cyc;
    fork
      send_byte(wb[31:24], 1'b1);
      begin
        while (cyc != k + OUT_LAT - 2) @(negedge clk);
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    idle(2);
    n_checks++; if (n_ovr !== 0) begin n_fail++; $display("FAIL same_overrun: got %0d pulses expected 0", n_ovr); end
    n_checks++; if (m_valid !== 1'b1 || m_data !== wb) begin n_fail++; $display("FAIL same_reload: got valid %b data %h expected 1 %h", m_valid, m_data, wb); end
    m_ready = 1'b1;
    idle(3);
    n_checks++; if (got_q.size() !== 2 || q_at(0) !== wa || q_at(1) !== wb) begin n_fail++; $display("FAIL same_order: got %0d words %h %h expected %h %h", got_q.size(), q_at(0), q_at(1), wa, wb); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    clear_counters(); m_ready = 1'b1; idle(4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rand_word());
      send_word(exp_q[i], 4 * CPB);
    end
    idle(CPB);
    n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL stream_count: got %0d words expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q_at(i) !== exp_q[i]) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", i, q_at(i), exp_q[i]); end
    end
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    clear_counters(); m_ready = 1'b1; idle(4);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle((TMO_BITS + 5) * CPB);
    n_checks++; if (n_tmo !== 1 || got_q.size() !== 0) begin n_fail++; $display("FAIL tmo_pulse: got %0d pulses %0d words expected 1 pulse 0 words", n_tmo, got_q.size()); end
    send_word(32'h0D0C0B0A, 0);
    idle(CPB);
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== 32'h0D0C0B0A) begin n_fail++; $display("FAIL tmo_word: got %0d words first %h expected 1 word 0D0C0B0A", got_q.size(), q_at(0)); end
  endtask
`else
  task automatic test_long_gap();
    clear_counters(); m_ready = 1'b1; idle(4);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(3 * TMO_BITS * CPB);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h81, 1'b1);
    idle(CPB);
    n_checks++; if (n_tmo !== 0) begin n_fail++; $display("FAIL gap_timeout: got %0d pulses expected 0", n_tmo); end
    n_checks++; if (got_q.size() !== 1 || q_at(0) !== 32'h817EC35A) begin n_fail++; $display("FAIL gap_word: got %0d words first %h expected 1 word 817EC35A", got_q.size(), q_at(0)); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_false_start();
    test_reset_mid();
    test_back_to_back();
    test_same_cycle();
    test_stream();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`else
    test_long_gap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
